hex_display_scanner: RTL and testbench
======================================

Name: hex_display_scanner

Overview:
- Downstream consumer of the ALU result bus: latches a 16-bit value and drives a 4-digit, common-anode, multiplexed 7-segment display as 4 hex nibbles.
- Replaces the ad-hoc display logic inside the ALU FPGA top, so other datapath stages (PC, register file, memory data) can reuse it.
- Time-multiplexes digits using a refresh prescaler.
- Outputs are registered and active-low, matching the board pinout.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range 2..2^20.
- CNT_W, 20, prescaler counter width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- value  input  16  data to display, normally ALU result
- load  input  1  capture value into display latch this edge
- blank  input  1  force all digits off while high
- seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
- an  output  4  anode drive, active-low, an[0] = rightmost digit (value[3:0])
- digit_tick  output  1  one-cycle pulse when the scan advances to the next digit

Behaviour:
- Reset (rst sampled high at posedge):
  - prescaler = 0, digit index = 0, latch = 16'h0000.
  - seg = 7'b1111111, an = 4'b1111, digit_tick = 0.
  - Reset mid-scan abandons the current slot immediately.
- Latch:
  - On the posedge with load=1 (and rst=0), latch <= value.
  - load is level-sampled: repeated loads simply overwrite.
  - value is ignored when load=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the wrap edge, digit index advances 0->1->2->3->0 (2-bit wrap) and digit_tick is registered high for exactly that one cycle.
- Output register, updated every cycle from the current index and latch:
  - an = ~(4'b0001 << index).
  - seg = decode(latch[4*index+3 : 4*index]).
  - Both outputs lag index/latch by exactly 1 cycle.
  - A load takes effect on seg no later than the second posedge after load; this also holds when load coincides with a tick edge (the new latch and the new index are used together).
- blank=1: an = 4'b1111, seg = 7'b1111111 on the next edge. Scanning and latching continue unaffected.
- Decode (active-low, {g..a}):
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000
  - 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0010000, A 0001000, b 0000011
  - C 1000110, d 0100001, E 0000110, F 0001110
- Decimal point is not driven (not a port).
- No state other than prescaler, index, latch and output registers.
- No combinational path from any input to any output.

Optional Feature:
- Macro HEX_DISPLAY_LZB_EN: leading-zero blanking.
- When defined:
  - While the current digit is not digit 0 and it and every higher digit of the latch are zero, that digit's anode is held off (an bit = 1, seg = 7'b1111111).
  - Digit 0 always displays.
  - Example: latch 16'h0030 lights digits 1 and 0 only.
- When undefined: all four digits always display, including leading zeros.
- Timing and the blank behaviour are identical with and without the macro.

Test Plan (REFRESH_DIV=4):
- Reset then idle: the cycle after the rst release edge (the first posedge with rst low) gives an=4'b1110, seg=7'b1000000. digit_tick pulses every 4 cycles and an rotates 1110->1101->1011->0111->1110.
- load=1 with value=16'h0003 (ALU ADD 1+2 result) for one cycle: within 2 edges, digit 0 shows seg=7'b0110000. Digits 1-3 show 7'b1000000 without the macro; with HEX_DISPLAY_LZB_EN, an bits 1-3 stay 1.
- value=16'hFFFF loaded, then full scan: every digit shows 7'b0001110. Then load 16'h89AB coincident with a digit_tick edge: from the 2nd edge after load, the digits read B,A,9,8 (0000011, 0001000, 0010000, 0000000) on an[0..3].
- blank=1 for 10 cycles mid-scan: an=4'b1111, seg=7'b1111111 throughout. After blank drops, the digit shown matches the free-running index; digit_tick spacing is unchanged at 4.
- rst asserted for 1 cycle while digit 2 is active and latch=16'h1234: outputs go to all-ones. Latch reads 0, so the next display is digit 0 with 7'b1000000, and the index restarts at 0.
- Decode sweep: load 16'h0000..16'h000F sequentially; digit 0 matches all 16 table entries.

Source files
------------

// File: rtl/hex_display_scanner.sv
// hex_display_scanner
//   Latches a 16-bit value and scans it onto a 4-digit, common-anode,
//   multiplexed 7-segment display as four hex nibbles.
//   A free-running prescaler sets how long each digit slot lasts.
//   All outputs are registered and active-low.
//
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (2..2^20)
//   CNT_W        prescaler width, 2^CNT_W >= REFRESH_DIV
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   value[15:0] data to display
//   load        capture value into the display latch on this edge
//   blank       force all digits off while high
//   seg[6:0]    segment drive, active-low, {g,f,e,d,c,b,a}
//   an[3:0]     anode drive, active-low, an[0] = rightmost digit (value[3:0])
//   digit_tick  one-cycle pulse when the scan advances to the next digit
//
// Optional build macro:
//   HEX_DISPLAY_LZB_EN  leading-zero blanking. Digits 1..3 are switched off
//                       while they and every higher digit are zero. Digit 0
//                       always displays.
module hex_display_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        digit_tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      latch_q, latch_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             tick_q, tick_d;
    logic [3:0]       nibble;
    logic             digit_off;

    // Hex nibble to active-low segments, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

`ifdef HEX_DISPLAY_LZB_EN
    // A digit is a leading zero when it and all digits above it are zero.
    function automatic logic leading_zero(input logic [15:0] v, input logic [1:0] i);
        case (i)
            2'd1:    leading_zero = (v[15:4] == 12'h000);
            2'd2:    leading_zero = (v[15:8] == 8'h00);
            2'd3:    leading_zero = (v[15:12] == 4'h0);
            default: leading_zero = 1'b0;
        endcase
    endfunction
`endif

    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        idx_d  = idx_q;
        tick_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            idx_d  = idx_q + 2'd1;
            tick_d = 1'b1;
        end

        latch_d = load ? value : latch_q;

        // Output stage works from the registered index and latch, so a load
        // coinciding with a tick edge shows the new digit with the new data.
        nibble = latch_q[{idx_q, 2'b00} +: 4];
`ifdef HEX_DISPLAY_LZB_EN
        digit_off = blank | leading_zero(latch_q, idx_q);
`else
        digit_off = blank;
`endif
        an_d  = digit_off ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d = digit_off ? 7'b1111111 : decode(nibble);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            latch_q <= 16'h0000;
            seg_q   <= 7'b1111111;
            an_q    <= 4'b1111;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            latch_q <= latch_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign digit_tick = tick_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Testbench for hex_display_scanner with REFRESH_DIV=4.
// Per-cycle vector groups cover scan rotation, loads, a load on a tick edge
// and blanking; hand sequences cover reset mid-scan and the decode table.
module tb_hex_display_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        blank;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        digit_tick;

    int total_cnt;
    int pass_cnt;

`ifdef HEX_DISPLAY_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    hex_display_scanner #(
        .REFRESH_DIV(4),
        .CNT_W      (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .blank     (blank),
        .seg       (seg),
        .an        (an),
        .digit_tick(digit_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;          // cycles in this group
        logic        ld;         // load on first cycle of group
        logic [15:0] val;
        logic        blk;        // blank level for whole group
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        lz;         // digit is a leading zero (blanked with LZB)
        logic        tick_last;  // digit_tick expected on last cycle only
    } vec_t;

    vec_t vecs[21];

    logic [6:0] dec_tab[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        else
            pass_cnt++;
    endtask

    initial begin
        logic [3:0] e_an;
        logic [6:0] e_seg;

        total_cnt = 0;
        pass_cnt  = 0;

        dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        //           n  ld  val       blk an       seg    lz tick
        vecs[0]  = '{4, 0, 16'h0000, 0, 4'b1110, 7'h40, 0, 1};
        vecs[1]  = '{4, 0, 16'h0000, 0, 4'b1101, 7'h40, 1, 1};
        vecs[2]  = '{4, 1, 16'h0003, 0, 4'b1011, 7'h40, 1, 1};
        vecs[3]  = '{4, 0, 16'h0000, 0, 4'b0111, 7'h40, 1, 1};
        vecs[4]  = '{4, 0, 16'h0000, 0, 4'b1110, 7'h30, 0, 1};
        vecs[5]  = '{1, 1, 16'hFFFF, 0, 4'b1101, 7'h40, 1, 0};
        vecs[6]  = '{3, 0, 16'h0000, 0, 4'b1101, 7'h0E, 0, 1};
        vecs[7]  = '{4, 0, 16'h0000, 0, 4'b1011, 7'h0E, 0, 1};
        vecs[8]  = '{4, 0, 16'h0000, 0, 4'b0111, 7'h0E, 0, 1};
        vecs[9]  = '{4, 0, 16'h0000, 0, 4'b1110, 7'h0E, 0, 1};
        vecs[10] = '{3, 0, 16'h0000, 0, 4'b1101, 7'h0E, 0, 0};
        vecs[11] = '{1, 1, 16'h89AB, 0, 4'b1101, 7'h0E, 0, 1};
        vecs[12] = '{4, 0, 16'h0000, 0, 4'b1011, 7'h10, 0, 1};
        vecs[13] = '{4, 0, 16'h0000, 0, 4'b0111, 7'h00, 0, 1};
        vecs[14] = '{4, 0, 16'h0000, 0, 4'b1110, 7'h03, 0, 1};
        vecs[15] = '{4, 0, 16'h0000, 0, 4'b1101, 7'h08, 0, 1};
        vecs[16] = '{4, 0, 16'h0000, 1, 4'b1111, 7'h7F, 0, 1};
        vecs[17] = '{4, 0, 16'h0000, 1, 4'b1111, 7'h7F, 0, 1};
        vecs[18] = '{2, 0, 16'h0000, 1, 4'b1111, 7'h7F, 0, 0};
        vecs[19] = '{2, 0, 16'h0000, 0, 4'b1110, 7'h03, 0, 1};
        vecs[20] = '{4, 0, 16'h0000, 0, 4'b1101, 7'h08, 0, 1};

        rst   = 1'b1;
        load  = 1'b0;
        value = 16'h0000;
        blank = 1'b0;
        repeat (3) step();
        chk("reset_an",   16'(an),         16'hF);
        chk("reset_seg",  16'(seg),        16'h7F);
        chk("reset_tick", 16'(digit_tick), 16'h0);

        rst = 1'b0;
        for (int i = 0; i < 21; i++) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                load  = (c == 0) ? vecs[i].ld : 1'b0;
                value = vecs[i].val;
                blank = vecs[i].blk;
                step();
                e_an  = vecs[i].an;
                e_seg = vecs[i].seg;
                if (LZB && vecs[i].lz) begin
                    e_an  = 4'b1111;
                    e_seg = 7'h7F;
                end
                chk($sformatf("v%0d_c%0d_an", i, c),   16'(an),  16'(e_an));
                chk($sformatf("v%0d_c%0d_seg", i, c),  16'(seg), 16'(e_seg));
                chk($sformatf("v%0d_c%0d_tick", i, c), 16'(digit_tick),
                    16'((vecs[i].tick_last && c == vecs[i].n - 1) ? 1 : 0));
            end
        end
        load  = 1'b0;
        blank = 1'b0;

        // Reset while digit 2 is showing 16'h1234.
        load  = 1'b1;
        value = 16'h1234;
        step();
        load = 1'b0;
        step();
        chk("pre_rst_an",  16'(an),  16'h000B);
        chk("pre_rst_seg", 16'(seg), 16'h0024);
        rst = 1'b1;
        step();
        chk("midrst_an",   16'(an),         16'hF);
        chk("midrst_seg",  16'(seg),        16'h7F);
        chk("midrst_tick", 16'(digit_tick), 16'h0);
        rst = 1'b0;
        step();
        chk("post_rst_an",  16'(an),  16'hE);
        chk("post_rst_seg", 16'(seg), 16'h40);
        step();
        step();
        chk("post_rst_notick", 16'(digit_tick), 16'h0);
        step();
        chk("post_rst_tick", 16'(digit_tick), 16'h1);
        step();
        chk("post_rst_dig1_an",  16'(an),  LZB ? 16'hF  : 16'hD);
        chk("post_rst_dig1_seg", 16'(seg), LZB ? 16'h7F : 16'h40);

        // Decode sweep on digit 0, each value loaded right after a reset.
        for (int v = 0; v < 16; v++) begin
            rst = 1'b1;
            step();
            rst   = 1'b0;
            load  = 1'b1;
            value = 16'(v);
            step();
            load = 1'b0;
            step();
            chk($sformatf("dec_%0h_an", v),  16'(an),  16'hE);
            chk($sformatf("dec_%0h_seg", v), 16'(seg), 16'(dec_tab[v]));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
